// File: rtl/nn_pkg.sv
// Shared types, word format and layer-geometry helpers
// for the neural network coefficient path.
package nn_pkg;

  localparam int N = 16;
  localparam int F = 8;
  localparam int I = 8;
  localparam int LMAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    VALID = 2'd2,
    DUMP  = 2'd3
  } state_t;

  function automatic int lsize(
    input logic [LMAX*32-1:0] lr,
    input int l
  );
    return int'(lr[l*32 +: 32]);
  endfunction

  function automatic int wt_count(
    input int ltot,
    input logic [LMAX*32-1:0] lr
  );
    int s;
    s = 0;
    for (int l = 1; l < ltot; l++)
      s += lsize(lr, l) * (lsize(lr, l - 1) + 1);
    return s;
  endfunction

endpackage

// File: rtl/coef_store_if.sv
// Coefficient memory port: the store is master,
// the memory is slave with one cycle of read latency.
interface coef_store_if #(
  parameter int A = 14,
  parameter int N = 16
);

  logic [A-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_we;
  logic [N-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/coef_seq.sv
// Walks coefficient slots layer by node by coef,
// keeping the flat slot index k alongside.
module coef_seq
  import nn_pkg::*;
#(
  parameter int LTOT = 3,
  parameter logic [LTOT*32-1:0] LR = {32'd1, 32'd3, 32'd2},
  parameter int WT = 13,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic          last,
  output logic [7:0]    l,
  output logic [7:0]    d,
  output logic [7:0]    c,
  output logic [KW-1:0] k
);

  localparam logic [LMAX*32-1:0] LRX = (LMAX*32)'(LR);

  logic c_end;
  logic d_end;

  // c runs one past the fan-in to cover the bias
  assign c_end = c == 8'(lsize(LRX, int'(l) - 1));
  assign d_end = d == 8'(lsize(LRX, int'(l)) - 1);
  assign last  = k == KW'(WT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l <= 8'd1;
      d <= 8'd0;
      c <= 8'd0;
      k <= '0;
    end else if (clear) begin
      l <= 8'd1;
      d <= 8'd0;
      c <= 8'd0;
      k <= '0;
    end else if (step) begin
      if (last) begin
        l <= 8'd1;
        d <= 8'd0;
        c <= 8'd0;
        k <= '0;
      end else begin
        k <= k + 1'b1;
        if (c_end) begin
          c <= 8'd0;
          if (d_end) begin
            d <= 8'd0;
            l <= l + 8'd1;
          end else begin
            d <= d + 8'd1;
          end
        end else begin
          c <= c + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/coef_store.sv
// Weight/bias register bank: loads from memory, takes
// backprop updates in one cycle, dumps back to memory.
module coef_store
  import nn_pkg::*;
#(
  parameter int N = nn_pkg::N,
  parameter int LTOT = 3,
  parameter logic [LTOT*32-1:0] LR = {32'd1, 32'd3, 32'd2},
  parameter int A = 14,
  parameter int BASE = 0,
  localparam int WT = wt_count(LTOT, (LMAX*32)'(LR))
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic            dump_start,
  input  logic            upd_we,
  input  logic [WT*N-1:0] upd_flat,
  coef_store_if.master    mem,
  output logic [WT*N-1:0] coef_flat,
  output logic            coef_valid,
  output logic            busy,
  output logic            done,
  output logic [7:0]      cur_l,
  output logic [7:0]      cur_d,
  output logic [7:0]      cur_c
);

  localparam int KW = (WT > 1) ? $clog2(WT + 1) : 1;

  state_t          state;
  logic [WT*N-1:0] bank;
  logic [KW-1:0]   k;
  logic [KW-1:0]   rd_idx;
  logic            rd_vld;
  logic            last;
  logic            accept;
  logic            step;

  assign coef_flat = bank;

  always_comb begin
    accept = 1'b0;
    unique case (state)
      IDLE:    accept = load_start;
      VALID:   accept = load_start | dump_start;
      default: accept = 1'b0;
    endcase
  end

  // done marks the closing cycle, so no slot advance then
  assign step = busy & ~done;

  coef_seq #(
    .LTOT(LTOT),
    .LR  (LR),
    .WT  (WT),
    .KW  (KW)
  ) u_seq (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .step (step),
    .last (last),
    .l    (cur_l),
    .d    (cur_d),
    .c    (cur_c),
    .k    (k)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mem.mem_addr  <= A'(BASE);
      mem.mem_wdata <= '0;
      mem.mem_we    <= 1'b0;
      bank          <= '0;
      coef_valid    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_idx        <= '0;
      rd_vld        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_start) begin
            state        <= LOAD;
            busy         <= 1'b1;
            mem.mem_addr <= A'(BASE);
            rd_vld       <= 1'b0;
          end
        end
        VALID: begin
          if (upd_we)
            bank <= upd_flat;
          if (load_start) begin
            state        <= LOAD;
            busy         <= 1'b1;
            mem.mem_addr <= A'(BASE);
            rd_vld       <= 1'b0;
          end else if (dump_start) begin
            state        <= DUMP;
            busy         <= 1'b1;
            mem.mem_addr <= A'(BASE);
            mem.mem_we   <= 1'b1;
            // slot 0 must already reflect a same-cycle update
            mem.mem_wdata <= upd_we ? upd_flat[N-1:0]
                                    : bank[N-1:0];
          end
        end
        LOAD: begin
          if (rd_vld)
            bank[int'(rd_idx)*N +: N] <= mem.mem_rdata;
          if (done) begin
            done   <= 1'b0;
            busy   <= 1'b0;
            rd_vld <= 1'b0;
            state  <= VALID;
          end else begin
            rd_idx <= k;
            rd_vld <= 1'b1;
            if (last) begin
              done       <= 1'b1;
              coef_valid <= 1'b1;
            end else begin
              mem.mem_addr <= mem.mem_addr + 1'b1;
            end
          end
        end
        DUMP: begin
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= VALID;
          end else if (last) begin
            mem.mem_we <= 1'b0;
            done       <= 1'b1;
          end else begin
            mem.mem_addr  <= mem.mem_addr + 1'b1;
            mem.mem_wdata <= bank[(int'(k) + 1)*N +: N];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coef_store.sv
// Directed + randomized bench for coef_store against
// a slot-order reference model and a memory model.
module tb_coef_store;

  localparam int N = 16;
  localparam int LTOT = 3;
  localparam logic [LTOT*32-1:0] LR = {32'd1, 32'd3, 32'd2};
  localparam int A = 14;
  localparam int BASE = 0;
  localparam int WT = 3 * (2 + 1) + 1 * (3 + 1);

  logic            clk;
  logic            rst;
  logic            load_start;
  logic            dump_start;
  logic            upd_we;
  logic [WT*N-1:0] upd_flat;
  logic [WT*N-1:0] coef_flat;
  logic            coef_valid;
  logic            busy;
  logic            done;
  logic [7:0]      cur_l;
  logic [7:0]      cur_d;
  logic [7:0]      cur_c;

  coef_store_if #(.A(A), .N(N)) mem ();

  coef_store #(
    .N   (N),
    .LTOT(LTOT),
    .LR  (LR),
    .A   (A),
    .BASE(BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .dump_start(dump_start),
    .upd_we    (upd_we),
    .upd_flat  (upd_flat),
    .mem       (mem),
    .coef_flat (coef_flat),
    .coef_valid(coef_valid),
    .busy      (busy),
    .done      (done),
    .cur_l     (cur_l),
    .cur_d     (cur_d),
    .cur_c     (cur_c)
  );

  int checks = 0;
  int errors = 0;
  int lrs [LTOT] = '{2, 3, 1};

  logic [N-1:0] memarr [64];
  logic [N-1:0] exp_bank [WT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: one-cycle read latency, write on mem_we
  always @(posedge clk) begin
    mem.mem_rdata <= memarr[mem.mem_addr[5:0]];
    if (mem.mem_we)
      memarr[mem.mem_addr[5:0]] = mem.mem_wdata;
  end

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WT*N-1:0] exp_flat();
    logic [WT*N-1:0] f;
    for (int i = 0; i < WT; i++)
      f[i*N +: N] = exp_bank[i];
    return f;
  endfunction

  function automatic void decode(input int k,
                                 output int l,
                                 output int d,
                                 output int c);
    int n;
    n = 0; l = 1; d = 0; c = 0;
    for (int li = 1; li < LTOT; li++)
      for (int di = 0; di < lrs[li]; di++)
        for (int ci = 0; ci <= lrs[li-1]; ci++) begin
          if (n == k) begin
            l = li; d = di; c = ci;
          end
          n++;
        end
  endfunction

  task automatic rand_mem();
    for (int i = 0; i < WT; i++)
      memarr[BASE + i] = N'($urandom);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_we"}, 256'(mem.mem_we), 256'(0));
    chk({tag, "_addr"}, 256'(mem.mem_addr), 256'(BASE));
    chk({tag, "_flat"}, 256'(coef_flat), 256'(0));
    chk({tag, "_valid"}, 256'(coef_valid), 256'(0));
    chk({tag, "_done"}, 256'(done), 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
  endtask

  task automatic run_load(input bit with_dump);
    int l, d, c;
    load_start = 1'b1;
    dump_start = with_dump;
    tick();
    load_start = 1'b0;
    dump_start = 1'b0;
    for (int j = 0; j < WT; j++) begin
      decode(j, l, d, c);
      chk("ld_addr", 256'(mem.mem_addr), 256'(BASE + j));
      chk("ld_we", 256'(mem.mem_we), 256'(0));
      chk("ld_done", 256'(done), 256'(0));
      chk("ld_busy", 256'(busy), 256'(1));
      chk("ld_lcd", {232'd0, cur_l, cur_d, cur_c},
          {232'd0, 8'(l), 8'(d), 8'(c)});
      tick();
    end
    chk("ld_fin_done", 256'(done), 256'(1));
    chk("ld_fin_valid", 256'(coef_valid), 256'(1));
    chk("ld_fin_we", 256'(mem.mem_we), 256'(0));
    for (int i = 0; i < WT; i++)
      exp_bank[i] = memarr[BASE + i];
    tick();
    chk("ld_post_done", 256'(done), 256'(0));
    chk("ld_post_busy", 256'(busy), 256'(0));
    chk("ld_bank", 256'(coef_flat), 256'(exp_flat()));
  endtask

  task automatic run_dump(input bit with_upd,
                          input logic [WT*N-1:0] upd);
    dump_start = 1'b1;
    upd_we     = with_upd;
    upd_flat   = upd;
    if (with_upd)
      for (int i = 0; i < WT; i++)
        exp_bank[i] = upd[i*N +: N];
    tick();
    dump_start = 1'b0;
    upd_we     = 1'b0;
    for (int j = 0; j < WT; j++) begin
      chk("dp_we", 256'(mem.mem_we), 256'(1));
      chk("dp_addr", 256'(mem.mem_addr), 256'(BASE + j));
      chk("dp_data", 256'(mem.mem_wdata), 256'(exp_bank[j]));
      load_start = (j == 4);
      upd_we     = (j == 4);
      if (j == 4)
        for (int i = 0; i < WT; i++)
          upd_flat[i*N +: N] = N'($urandom);
      tick();
    end
    load_start = 1'b0;
    upd_we     = 1'b0;
    chk("dp_fin_we", 256'(mem.mem_we), 256'(0));
    chk("dp_fin_done", 256'(done), 256'(1));
    tick();
    chk("dp_post_done", 256'(done), 256'(0));
    chk("dp_post_busy", 256'(busy), 256'(0));
    chk("dp_post_valid", 256'(coef_valid), 256'(1));
    chk("dp_bank", 256'(coef_flat), 256'(exp_flat()));
    for (int i = 0; i < WT; i++)
      chk("dp_mem", 256'(memarr[BASE + i]), 256'(exp_bank[i]));
  endtask

  initial begin
    logic [WT*N-1:0] upd;
    rst        = 1'b1;
    load_start = 1'b0;
    dump_start = 1'b0;
    upd_we     = 1'b0;
    upd_flat   = '0;
    for (int i = 0; i < 64; i++)
      memarr[i] = '0;
    for (int i = 0; i < WT; i++)
      exp_bank[i] = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_reset_state("rst");
    chk("rst_lcd", {232'd0, cur_l, cur_d, cur_c},
        {232'd0, 8'd1, 8'd0, 8'd0});

    // requests the idle store must ignore
    dump_start = 1'b1;
    upd_we     = 1'b1;
    for (int i = 0; i < WT; i++)
      upd_flat[i*N +: N] = N'($urandom);
    tick();
    dump_start = 1'b0;
    upd_we     = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("idle_we", 256'(mem.mem_we), 256'(0));
      chk("idle_busy", 256'(busy), 256'(0));
      tick();
    end
    chk("idle_flat", 256'(coef_flat), 256'(0));

    for (int i = 0; i < WT; i++)
      memarr[BASE + i] = 16'h0100 + N'(i);
    run_load(1'b0);
    chk("slot12", 256'(coef_flat[12*N +: N]), 256'(16'h010C));
    chk("slot8", 256'(coef_flat[8*N +: N]), 256'(16'h0108));

    for (int i = 0; i < WT; i++)
      upd[i*N +: N] = 16'h0200 + N'(i);
    run_dump(1'b1, upd);

    // both starts together: load must win
    rand_mem();
    run_load(1'b1);

    // async reset in the middle of a load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int j = 0; j < 5; j++)
      tick();
    chk("mid_addr", 256'(mem.mem_addr), 256'(BASE + 5));
    rst = 1'b1;
    #2;
    check_reset_state("arst");
    for (int i = 0; i < WT; i++)
      exp_bank[i] = '0;
    tick();
    rst = 1'b0;
    tick();
    check_reset_state("arst_rel");
    rand_mem();
    run_load(1'b0);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < WT; i++)
        upd[i*N +: N] = N'($urandom);
      case ($urandom_range(0, 2))
        0: begin
          rand_mem();
          run_load(1'b0);
        end
        1: run_dump(1'b1, upd);
        default: run_dump(1'b0, upd);
      endcase
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coef_store.md
Name: coef_store

Overview:
- Coefficient store for the neural network datapath. It holds every weight and bias, and it is the memory-side responder to the control unit's load and save phases.
- LOAD: streams coefficients from coefficient memory (1-cycle read latency) into a flat register bank. The bank drives the layer nodes in parallel.
- Backprop results are captured into the bank in one cycle.
- DUMP: writes the bank back to memory, one word per cycle.

Parameters:
- N, `n, fixed-point word width (from fixed_point.vh).
- LTOT, 3, number of layers including the input layer.
- LR, {32'd1,32'd3,32'd2}, packed layer sizes, 32 bits per layer; LR[0 +: 32] is the input count.
- A, 14, memory address width.
- BASE, 0, first coefficient address in memory.
- WT (localparam), sum over l=1..LTOT-1 of LR[l]*(LR[l-1]+1); default 13.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- load_start, input, 1, request load from memory.
- dump_start, input, 1, request write-back to memory.
- upd_we, input, 1, capture upd_flat into the bank.
- upd_flat, input, WT*N, updated coefficients from backprop.
- mem_rdata, input, N, memory read data; valid the cycle after mem_addr is presented.
- mem_addr, output, A, memory address.
- mem_wdata, output, N, memory write data.
- mem_we, output, 1, memory write enable.
- coef_flat, output, WT*N, register bank; slot k at [k*N +: N].
- coef_valid, output, 1, bank holds a completed load.
- busy, output, 1, high in LOAD or DUMP.
- done, output, 1, one-cycle pulse at the end of LOAD or DUMP.
- cur_l, output, 8, layer of the current slot.
- cur_d, output, 8, node of the current slot.
- cur_c, output, 8, coef of the current slot.

Behaviour:
- Reset (async):
  - State IDLE.
  - mem_addr=BASE, mem_wdata=0, mem_we=0.
  - coef_flat=0, coef_valid=0, busy=0, done=0.
  - cur_l=1, cur_d=0, cur_c=0.
  - Reset during LOAD or DUMP aborts the operation immediately and clears the bank.
- Slot order:
  - Loops are layer l=1..LTOT-1, then node d=0..LR[l]-1, then coef c=0..LR[l-1].
  - c<LR[l-1] is a weight; c=LR[l-1] is the bias.
  - k increments across that order with no gaps.
- States: IDLE(0), LOAD(1), VALID(2), DUMP(3).
- IDLE:
  - load_start moves to LOAD.
  - dump_start and upd_we are ignored.
- LOAD:
  - Cycle j (j=0..WT-1, first cycle after acceptance): mem_addr=BASE+j.
  - Cycle j+1: slot j <= mem_rdata.
  - Cycle WT: final write of slot WT-1, done=1, coef_valid=1, move to VALID.
  - Total WT+1 cycles. cur_l/d/c track the address being issued.
- VALID:
  - upd_we=1 loads all WT slots from upd_flat in that cycle.
  - load_start moves to LOAD (coef_valid stays 1 until reset).
  - Otherwise dump_start moves to DUMP; load_start wins if both are asserted.
  - upd_we asserted together with a start: capture happens first, so DUMP writes the updated values.
- DUMP:
  - Cycle j (j=0..WT-1): mem_addr=BASE+j, mem_wdata=slot j, mem_we=1.
  - Cycle WT: mem_we=0, done=1, move to VALID. Total WT+1 cycles.
- General rules:
  - Starts and upd_we arriving while busy are ignored.
  - done is high for exactly one cycle.
  - mem_we=0 outside DUMP.
  - Address arithmetic is modulo 2^A.
  - Index counters wrap:
    - c returns to 0 after LR[l-1], and d increments.
    - d returns to 0 after LR[l]-1, and l increments.
    - After the last slot, l returns to 1.

Decomposition:
- Shared package nn_pkg:
  - State encoding.
  - N/F/I from fixed_point.vh.
  - Constant function wt_count(LTOT, LR).
  - Accessor for the layer size LR[l].
- One sub-module coef_seq:
  - Holds the l/d/c/k counters with wrap logic.
  - Ports clear, step, last.
  - Shared by LOAD and DUMP.

Test Plan:
- Reset: assert rst mid-cycle -> immediately mem_we=0, coef_flat=0, coef_valid=0, done=0, mem_addr=BASE.
- Load: memory[k]=16'h0100+k, pulse load_start -> mem_addr 0..12 on cycles 1..13; done on cycle 14; slot 12=16'h010C; at k=9, cur_l=2, cur_d=0, cur_c=0; slot 8 (layer-1 node-2 bias)=16'h0108.
- Update+dump: in VALID set upd slot k=16'h0200+k with upd_we=1 and dump_start=1 in the same cycle -> 13 writes, addr 0..12 / data 16'h0200..16'h020C, then a done pulse and return to VALID.
- Illegal requests: dump_start and upd_we in IDLE -> no mem_we and coef_flat unchanged; load_start during DUMP -> ignored, DUMP completes all 13 writes.
- Reset mid-load: rst while at k=5 -> state IDLE, bank cleared; a following load_start completes normally in 14 cycles.
- Priority: load_start and dump_start together in VALID -> LOAD entered, mem_we stays 0 throughout.
